// File: rtl/sram_if_pkg.sv
// ---------------------------------------------------------------------------
// sram_if_pkg
// Shared definitions for the SRAM-like bus used between the core masters and
// the memory/bridge side.
//   OWNER_INST / OWNER_DATA : one-bit encoding of which master owns a request
//   sram_size_e             : encoding of the transfer size on *_size
// ---------------------------------------------------------------------------
package sram_if_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sram_size_e;

endpackage : sram_if_pkg

// File: rtl/owner_fifo.sv
// ---------------------------------------------------------------------------
// owner_fifo
// Small in-order FIFO of one-bit owner tags. One entry is written for every
// request the slave accepts. One entry is retired for every response the
// slave returns, so the head always names the master of the oldest
// unanswered request.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   i_push         : write i_pushOwner at the tail (caller guarantees not full)
//   i_pushOwner    : owner tag to store
//   i_pop          : retire the head entry (ignored while empty)
//   o_head         : owner tag at the head
//   o_count        : number of stored entries (registered)
// ---------------------------------------------------------------------------
module owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pushOwner,
  input  logic                   i_pop,
  output logic                   o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_rdPtr;
  logic [PW-1:0]    r_wrPtr;
  logic [PW:0]      r_count;
  logic             w_doPop;

  // A pop on an empty FIFO would corrupt the pointers, so it is filtered here
  // as well as in the arbiter.
  assign w_doPop = i_pop && (r_count != '0);

  // Storage and pointers. DEPTH is a power of two, so the pointers wrap
  // naturally when they overflow their width. A simultaneous push and pop
  // advances both pointers and leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem   <= '0;
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= i_pushOwner;
        r_wrPtr        <= r_wrPtr + PW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({i_push, w_doPop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule : owner_fifo

// File: rtl/sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter
// Shares one SRAM-like slave port between the instruction master (IF) and
// the data master (EX/MEM). Data has fixed priority over instruction. A
// request that the slave stalls keeps its grant until it is accepted.
// Accepted requests are tagged in an owner FIFO, so the in-order slave
// responses can be routed back to the master that issued them.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   inst_* (in)           : instruction master request and payload
//   inst_addr_ok/data_ok  : instruction accept / response strobes
//   inst_rdata            : instruction read data (always mem_rdata)
//   data_* (in)           : data master request and payload
//   data_addr_ok/data_ok  : data accept / response strobes
//   data_rdata            : data read data (always mem_rdata)
//   mem_* (out)           : request and payload presented to the slave
//   mem_addr_ok/data_ok   : slave accept / in-order response strobes
//   mem_rdata             : slave read data
//   pending_cnt           : outstanding accepted-but-unanswered requests
//   err_unexp             : sticky, set by a response with nothing outstanding
// ---------------------------------------------------------------------------
module sram_bus_arbiter
  import sram_if_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  // instruction master
  input  logic                           inst_req,
  input  logic                           inst_wr,
  input  logic [1:0]                     inst_size,
  input  logic [DATA_W/8-1:0]            inst_wstrb,
  input  logic [ADDR_W-1:0]              inst_addr,
  input  logic [DATA_W-1:0]              inst_wdata,
  output logic                           inst_addr_ok,
  output logic                           inst_data_ok,
  output logic [DATA_W-1:0]              inst_rdata,
  // data master
  input  logic                           data_req,
  input  logic                           data_wr,
  input  logic [1:0]                     data_size,
  input  logic [DATA_W/8-1:0]            data_wstrb,
  input  logic [ADDR_W-1:0]              data_addr,
  input  logic [DATA_W-1:0]              data_wdata,
  output logic                           data_addr_ok,
  output logic                           data_data_ok,
  output logic [DATA_W-1:0]              data_rdata,
  // slave side
  output logic                           mem_req,
  output logic                           mem_wr,
  output logic [1:0]                     mem_size,
  output logic [DATA_W/8-1:0]            mem_wstrb,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic                           mem_addr_ok,
  input  logic                           mem_data_ok,
  input  logic [DATA_W-1:0]              mem_rdata,
  // status
  output logic [$clog2(OUTSTANDING):0]   pending_cnt,
  output logic                           err_unexp
);

  localparam int CW = $clog2(OUTSTANDING) + 1;

  logic          r_lockValid;
  logic          r_lockOwner;
  logic          r_errUnexp;

  logic          w_owner;
  logic          w_ownerReq;
  logic          w_full;
  logic          w_memReq;
  logic          w_accept;
  logic          w_respValid;
  logic          w_head;
  logic [CW-1:0] w_count;

  // Grant selection. A stalled request holds the bus through the lock, so a
  // data request raised mid-stall cannot change the slave-facing payload.
  always_comb begin
    w_owner    = OWNER_INST;
    w_ownerReq = 1'b0;
    if (r_lockValid) begin
      w_owner = r_lockOwner;
    end else if (data_req) begin
      w_owner = OWNER_DATA;
    end
    w_ownerReq = (w_owner == OWNER_DATA) ? data_req : inst_req;
  end

  // Full is taken from the registered count on purpose: a slot freed by a
  // response becomes usable only on the following cycle, which keeps the
  // response path out of the request path. While locked nothing can be
  // pushed, so full cannot rise and mem_req never drops mid-request.
  assign w_full      = (w_count == CW'(OUTSTANDING));
  assign w_memReq    = w_ownerReq && !w_full && !reset;
  assign w_accept    = w_memReq && mem_addr_ok;
  assign w_respValid = mem_data_ok && (w_count != '0) && !reset;

  // Payload mux towards the slave follows the granted owner.
  always_comb begin
    mem_wr    = inst_wr;
    mem_size  = inst_size;
    mem_wstrb = inst_wstrb;
    mem_addr  = inst_addr;
    mem_wdata = inst_wdata;
    if (w_owner == OWNER_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  assign mem_req      = w_memReq;
  assign inst_addr_ok = w_accept && (w_owner == OWNER_INST);
  assign data_addr_ok = w_accept && (w_owner == OWNER_DATA);

  // Responses are strictly in order, so the FIFO head names their owner.
  assign inst_data_ok = w_respValid && (w_head == OWNER_INST);
  assign data_data_ok = w_respValid && (w_head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign pending_cnt  = w_count;
  assign err_unexp    = r_errUnexp;

  // Grant lock. It is set when the slave stalls the presented request and
  // cleared on acceptance. The owner is captured so the same master is
  // presented until its request goes through.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lockValid <= 1'b0;
      r_lockOwner <= OWNER_INST;
    end else if (w_accept) begin
      r_lockValid <= 1'b0;
    end else if (w_memReq) begin
      r_lockValid <= 1'b1;
      r_lockOwner <= w_owner;
    end
  end

  // A response with nothing outstanding indicates a protocol error on the
  // slave side. It is remembered until the next reset so software can see it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_errUnexp <= 1'b0;
    end else if (mem_data_ok && (w_count == '0)) begin
      r_errUnexp <= 1'b1;
    end
  end

  owner_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_ownerFifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_accept),
    .i_pushOwner(w_owner),
    .i_pop      (w_respValid),
    .o_head     (w_head),
    .o_count    (w_count)
  );

endmodule : sram_bus_arbiter

// File: tb/tb_sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_arbiter
// Directed scenarios plus a randomized run for sram_bus_arbiter. In the
// randomized run, expected behaviour comes from a queue-based model of the
// arbitration rules.
// ---------------------------------------------------------------------------
module tb_sram_bus_arbiter;

  localparam int OUT = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int PL  = 1 + 2 + DW/8 + AW + DW;

  logic            clk;
  logic            reset;
  logic            inst_req, inst_wr, data_req, data_wr;
  logic [1:0]      inst_size, data_size;
  logic [DW/8-1:0] inst_wstrb, data_wstrb;
  logic [AW-1:0]   inst_addr, data_addr;
  logic [DW-1:0]   inst_wdata, data_wdata;
  logic            inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DW-1:0]   inst_rdata, data_rdata;
  logic            mem_req, mem_wr;
  logic [1:0]      mem_size;
  logic [DW/8-1:0] mem_wstrb;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_addr_ok, mem_data_ok;
  logic [DW-1:0]   mem_rdata;
  logic [$clog2(OUT):0] pending_cnt;
  logic            err_unexp;

  int errors;
  int checks;

  sram_bus_arbiter #(.OUTSTANDING(OUT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .pending_cnt(pending_cnt), .err_unexp(err_unexp)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to just after the next rising edge, where inputs are changed and
  // registered outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop every master and slave strobe.
  task automatic applyIdle();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = '0;
    inst_addr = '0; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = '0;
    data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  // Reset behaviour: handshake outputs are forced low while reset is high,
  // and state comes out cleared.
  task automatic test_reset();
    applyIdle();
    reset = 1'b1;
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_req: got %b exp 0", mem_req); end
    checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL rst_data_addr_ok: got %b exp 0", data_addr_ok); end
    checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL rst_inst_data_ok: got %b exp 0", inst_data_ok); end
    tick();
    applyIdle();
    reset = 1'b0;
    tick();
    checks++; if (pending_cnt !== 2'd0) begin errors++; $display("[TB] FAIL rst_pending: got %0d exp 0", pending_cnt); end
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b exp 0", err_unexp); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle_mem_req: got %b exp 0", mem_req); end
  endtask

  // Single instruction fetch with zero-latency accept and a response two
  // cycles later.
  task automatic test_inst_single();
    tick();
    inst_req = 1'b1; inst_addr = 32'h1c000000; mem_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL t1_inst_addr_ok: got %b exp 1", inst_addr_ok); end
    checks++; if (mem_addr !== 32'h1c000000) begin errors++; $display("[TB] FAIL t1_mem_addr: got %h exp 1c000000", mem_addr); end
    tick();
    applyIdle();
    checks++; if (pending_cnt !== 2'd1) begin errors++; $display("[TB] FAIL t1_pending1: got %0d exp 1", pending_cnt); end
    @(negedge clk);
    checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL t1_early_data_ok: got %b exp 0", inst_data_ok); end
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h02800c0c;
    @(negedge clk);
    checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL t1_inst_data_ok: got %b exp 1", inst_data_ok); end
    checks++; if (data_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL t1_data_data_ok: got %b exp 0", data_data_ok); end
    checks++; if (inst_rdata !== 32'h02800c0c) begin errors++; $display("[TB] FAIL t1_rdata: got %h exp 02800c0c", inst_rdata); end
    tick();
    applyIdle();
    checks++; if (pending_cnt !== 2'd0) begin errors++; $display("[TB] FAIL t1_pending0: got %0d exp 0", pending_cnt); end
    @(negedge clk);
    checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL t1_late_data_ok: got %b exp 0", inst_data_ok); end
  endtask

  // Both masters request together: data wins, instruction goes next cycle.
  task automatic test_priority();
    tick();
    inst_req = 1'b1; inst_addr = 32'h1c000010;
    data_req = 1'b1; data_addr = 32'h00000800; mem_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h00000800) begin errors++; $display("[TB] FAIL t2_mem_addr0: got %h exp 00000800", mem_addr); end
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL t2_data_addr_ok: got %b exp 1", data_addr_ok); end
    checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL t2_inst_addr_ok0: got %b exp 0", inst_addr_ok); end
    tick();
    data_req = 1'b0;
    @(negedge clk);
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL t2_inst_addr_ok1: got %b exp 1", inst_addr_ok); end
    checks++; if (mem_addr !== 32'h1c000010) begin errors++; $display("[TB] FAIL t2_mem_addr1: got %h exp 1c000010", mem_addr); end
    tick();
    applyIdle();
    mem_data_ok = 1'b1;
    tick();
    tick();
    applyIdle();
    checks++; if (pending_cnt !== 2'd0) begin errors++; $display("[TB] FAIL t2_drained: got %0d exp 0", pending_cnt); end
  endtask

  // A stalled instruction request keeps the bus even when data arrives.
  task automatic test_lock();
    tick();
    inst_req = 1'b1; inst_addr = 32'h1c000020; inst_wr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        data_req = 1'b1; data_addr = 32'h00000900; data_wr = 1'b1;
      end
      @(negedge clk);
      checks++; if (mem_addr !== 32'h1c000020) begin errors++; $display("[TB] FAIL t3_mem_addr_c%0d: got %h exp 1c000020", c, mem_addr); end
      checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL t3_data_addr_ok_c%0d: got %b exp 0", c, data_addr_ok); end
      tick();
    end
    mem_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL t3_inst_accept: got %b exp 1", inst_addr_ok); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL t3_mem_wr: got %b exp 0", mem_wr); end
    tick();
    inst_req = 1'b0;
    @(negedge clk);
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL t3_data_accept: got %b exp 1", data_addr_ok); end
    checks++; if (mem_addr !== 32'h00000900) begin errors++; $display("[TB] FAIL t3_mem_addr4: got %h exp 00000900", mem_addr); end
    tick();
    applyIdle();
    mem_data_ok = 1'b1;
    @(negedge clk);
    checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL t3_first_resp: got %b exp 1", inst_data_ok); end
    tick();
    tick();
    applyIdle();
  endtask

  // Outstanding limit: the third request waits until a slot was freed on a
  // previous cycle.
  task automatic test_full();
    tick();
    data_req = 1'b1; data_addr = 32'h00000100; mem_addr_ok = 1'b1;
    tick();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c000004;
    tick();
    inst_addr = 32'h1c000008;
    checks++; if (pending_cnt !== 2'd2) begin errors++; $display("[TB] FAIL t4_pending2: got %0d exp 2", pending_cnt); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL t4_full_mem_req: got %b exp 0", mem_req); end
    checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL t4_full_addr_ok: got %b exp 0", inst_addr_ok); end
    tick();
    mem_data_ok = 1'b1;
    @(negedge clk);
    checks++; if (data_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL t4_resp_data: got %b exp 1", data_data_ok); end
    checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL t4_resp_inst: got %b exp 0", inst_data_ok); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL t4_same_cycle_req: got %b exp 0", mem_req); end
    tick();
    mem_data_ok = 1'b0;
    checks++; if (pending_cnt !== 2'd1) begin errors++; $display("[TB] FAIL t4_pending1: got %0d exp 1", pending_cnt); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL t4_next_req: got %b exp 1", mem_req); end
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL t4_next_accept: got %b exp 1", inst_addr_ok); end
    tick();
    applyIdle();
    mem_data_ok = 1'b1;
    tick();
    tick();
    applyIdle();
    checks++; if (pending_cnt !== 2'd0) begin errors++; $display("[TB] FAIL t4_drained: got %0d exp 0", pending_cnt); end
  endtask

  // Writes from data then instruction, responses strictly in order.
  task automatic test_order();
    tick();
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h00000a00; data_wstrb = 4'hf;
    mem_addr_ok = 1'b1;
    tick();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c000030;
    tick();
    applyIdle();
    tick();
    mem_data_ok = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      checks++; if (data_data_ok !== (r == 0)) begin errors++; $display("[TB] FAIL t5_data_ok_r%0d: got %b exp %b", r, data_data_ok, (r == 0)); end
      checks++; if (inst_data_ok !== (r == 1)) begin errors++; $display("[TB] FAIL t5_inst_ok_r%0d: got %b exp %b", r, inst_data_ok, (r == 1)); end
      tick();
    end
    applyIdle();
  endtask

  // Randomized traffic checked against a queue model of the arbitration
  // rules: data-over-instruction priority, a stalled request keeps the bus,
  // at most OUT requests outstanding, and in-order response routing.
  task automatic test_random();
    bit           ownerQ[$];
    bit           stuck;
    bit           stuckOwner;
    bit           instHold;
    bit           dataHold;
    bit           expOwner;
    bit           expReq;
    bit           expAccept;
    bit           expResp;
    bit           respOwner;
    logic [PL-1:0] expPayload;
    logic [PL-1:0] gotPayload;
    stuck = 1'b0; stuckOwner = 1'b0; instHold = 1'b0; dataHold = 1'b0;
    tick();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!instHold) begin
        inst_req = ($urandom_range(0, 2) != 0);
        inst_wr = $urandom_range(0, 1) == 1; inst_size = 2'($urandom_range(0, 2));
        inst_wstrb = 4'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (!dataHold) begin
        data_req = ($urandom_range(0, 2) == 0);
        data_wr = $urandom_range(0, 1) == 1; data_size = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 3) != 0);
      mem_data_ok = (ownerQ.size() > 0) && ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      checks++; if (pending_cnt !== 2'(ownerQ.size())) begin errors++; $display("[TB] FAIL rnd_pending c%0d: got %0d exp %0d", cyc, pending_cnt, ownerQ.size()); end
      @(negedge clk);
      expOwner   = stuck ? stuckOwner : data_req;
      expReq     = (expOwner ? data_req : inst_req) && (ownerQ.size() < OUT);
      expAccept  = expReq && mem_addr_ok;
      expResp    = mem_data_ok && (ownerQ.size() > 0);
      respOwner  = (ownerQ.size() > 0) ? ownerQ[0] : 1'b0;
      expPayload = expOwner ? {data_wr, data_size, data_wstrb, data_addr, data_wdata}
                            : {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
      gotPayload = {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};
      checks++; if (mem_req !== expReq) begin errors++; $display("[TB] FAIL rnd_mem_req c%0d: got %b exp %b", cyc, mem_req, expReq); end
      if (expReq) begin
        checks++; if (gotPayload !== expPayload) begin errors++; $display("[TB] FAIL rnd_payload c%0d: got %h exp %h", cyc, gotPayload, expPayload); end
      end
      checks++; if (inst_addr_ok !== (expAccept && !expOwner)) begin errors++; $display("[TB] FAIL rnd_inst_addr_ok c%0d: got %b exp %b", cyc, inst_addr_ok, expAccept && !expOwner); end
      checks++; if (data_addr_ok !== (expAccept && expOwner)) begin errors++; $display("[TB] FAIL rnd_data_addr_ok c%0d: got %b exp %b", cyc, data_addr_ok, expAccept && expOwner); end
      checks++; if (inst_data_ok !== (expResp && !respOwner)) begin errors++; $display("[TB] FAIL rnd_inst_data_ok c%0d: got %b exp %b", cyc, inst_data_ok, expResp && !respOwner); end
      checks++; if (data_data_ok !== (expResp && respOwner)) begin errors++; $display("[TB] FAIL rnd_data_data_ok c%0d: got %b exp %b", cyc, data_data_ok, expResp && respOwner); end
      checks++; if ((inst_rdata !== mem_rdata) || (data_rdata !== mem_rdata)) begin errors++; $display("[TB] FAIL rnd_rdata c%0d: got %h/%h exp %h", cyc, inst_rdata, data_rdata, mem_rdata); end
      checks++; if (err_unexp !== 1'b0) begin errors++; $display("[TB] FAIL rnd_err c%0d: got %b exp 0", cyc, err_unexp); end
      if (expResp) void'(ownerQ.pop_front());
      if (expAccept) ownerQ.push_back(expOwner);
      if (expAccept) stuck = 1'b0;
      else if (expReq) begin stuck = 1'b1; stuckOwner = expOwner; end
      instHold = inst_req && !(expAccept && !expOwner);
      dataHold = data_req && !(expAccept && expOwner);
      tick();
    end
    applyIdle();
  endtask

  // Response with nothing outstanding: no routing, sticky error, cleared by
  // reset together with all handshake outputs.
  task automatic test_spurious();
    mem_data_ok = 1'b1;
    while (pending_cnt != 0) tick();
    tick();
    applyIdle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    mem_data_ok = 1'b1;
    @(negedge clk);
    checks++; if ((inst_data_ok !== 1'b0) || (data_data_ok !== 1'b0)) begin errors++; $display("[TB] FAIL t6_data_ok: got %b%b exp 00", inst_data_ok, data_data_ok); end
    tick();
    mem_data_ok = 1'b0;
    checks++; if (err_unexp !== 1'b1) begin errors++; $display("[TB] FAIL t6_err_set: got %b exp 1", err_unexp); end
    checks++; if (pending_cnt !== 2'd0) begin errors++; $display("[TB] FAIL t6_no_pop: got %0d exp 0", pending_cnt); end
    tick();
    tick();
    checks++; if (err_unexp !== 1'b1) begin errors++; $display("[TB] FAIL t6_err_held: got %b exp 1", err_unexp); end
    reset = 1'b1;
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    @(negedge clk);
    checks++; if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin errors++; $display("[TB] FAIL t6_rst_outputs: got %b exp 00000", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    tick();
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("[TB] FAIL t6_err_clear: got %b exp 0", err_unexp); end
    applyIdle();
    reset = 1'b0;
  endtask

  // Scenario sequence and summary.
  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    applyIdle();
    test_reset();
    test_inst_single();
    test_priority();
    test_lock();
    test_full();
    test_order();
    test_random();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sram_bus_arbiter

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory port between the core's instruction master (IF stage) and data master (EX/MEM stages).
- Sits between the core and the memory/bridge side, replacing two separate SRAM ports with a single one.
- Grants requests with fixed data-over-instruction priority, and holds the grant while the slave stalls a request.
- Tracks outstanding accepted requests in an owner FIFO so that in-order slave responses return to the correct master.

Parameters:
OUTSTANDING, 2, maximum accepted-but-unanswered requests; power of two, at least 2.
ADDR_W, 32, address width.
DATA_W, 32, data width; wstrb width is DATA_W/8.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_req / inst_wr / inst_size / inst_wstrb / inst_addr / inst_wdata  in  1/1/2/DATA_W/8/ADDR_W/DATA_W  instruction master request
inst_addr_ok  out  1  instruction request accepted this cycle
inst_data_ok  out  1  instruction response valid this cycle
inst_rdata  out  DATA_W  instruction read data
data_req / data_wr / data_size / data_wstrb / data_addr / data_wdata  in  1/1/2/DATA_W/8/ADDR_W/DATA_W  data master request
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  data response valid this cycle
data_rdata  out  DATA_W  data read data
mem_req / mem_wr / mem_size / mem_wstrb / mem_addr / mem_wdata  out  1/1/2/DATA_W/8/ADDR_W/DATA_W  request to slave
mem_addr_ok  in  1  slave accepted request
mem_data_ok  in  1  slave response valid; responses are in order, for writes as well as reads
mem_rdata  in  DATA_W  slave read data
pending_cnt  out  $clog2(OUTSTANDING)+1  number of outstanding requests (registered)
err_unexp  out  1  sticky flag: mem_data_ok arrived with no request outstanding

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Registered state:
  - lock_valid and lock_owner (0 = inst, 1 = data);
  - owner FIFO of OUTSTANDING 1-bit entries, with read pointer, write pointer and count;
  - err_unexp.
- Reset: FIFO empty, lock_valid=0, pending_cnt=0, err_unexp=0.
- While reset is high, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are forced to 0.
- Grant (combinational):
  - if lock_valid, owner = lock_owner;
  - otherwise owner = data if data_req, else inst.
- full = (count == OUTSTANDING), computed from the registered count. A slot freed by a pop is therefore usable from the next cycle, not the same cycle.
- mem_req = owner's req AND NOT full. mem_wr/size/wstrb/addr/wdata are muxed from the owner.
- Accept = mem_req AND mem_addr_ok. The owner's *_addr_ok = accept; the other master's addr_ok = 0.
- Zero-latency path: inst_req alone, not full, slave ready gives accept in the same cycle.
- Lock:
  - mem_req=1 AND mem_addr_ok=0 → lock_valid<=1, lock_owner<=owner.
  - accept → lock_valid<=0.
  - While locked, a newly raised higher-priority data_req does not change mem_* outputs.
  - Masters hold req and payload stable until addr_ok; the arbiter does not check this.
  - While locked, count cannot rise, so full cannot become true and mem_req never drops mid-request.
- FIFO:
  - push owner on accept; pop on mem_data_ok when count>0;
  - simultaneous push and pop: count unchanged, both pointers advance;
  - pointers wrap modulo OUTSTANDING.
- Response routing:
  - when mem_data_ok and count>0, the head owner's *_data_ok = 1 for exactly that cycle;
  - inst_rdata = data_rdata = mem_rdata at all times.
- Spurious response: mem_data_ok with count==0 → no *_data_ok, no pop, err_unexp<=1 (held until reset).
- The slave never asserts data_ok in the same cycle as the addr_ok of that same request; responses arrive at least 1 cycle after acceptance.
- Starvation of inst under continuous data_req is accepted by design; the core issues at most one data request per instruction.

Decomposition:
- Shared package sram_if_pkg: owner encodings OWNER_INST=1'b0 and OWNER_DATA=1'b1, and the SRAM size encodings (0 = byte, 1 = half, 2 = word).
- One sub-module: owner_fifo (1-bit wide, depth OUTSTANDING, push/pop/count/head), instantiated once.

Test Plan:
1. inst_req, addr 0x1c000000, mem_addr_ok=1 in cycle 0; mem_data_ok in cycle 2 with rdata 0x02800c0c → inst_addr_ok=1 in cycle 0; inst_data_ok=1 in cycle 2 only; inst_rdata=0x02800c0c; data_data_ok stays 0; pending_cnt 1 then 0.
2. inst_req and data_req together (data_addr 0x00000800), slave always ready → cycle 0: mem_addr=0x800, data_addr_ok=1, inst_addr_ok=0. Cycle 1: inst granted.
3. inst_req alone with mem_addr_ok=0 for 3 cycles; data_req rises in cycle 1 → mem_addr stays the inst address until addr_ok in cycle 3, then data is granted in cycle 4.
4. OUTSTANDING=2, two accepted requests, no response, third request pending → mem_req=0 and pending_cnt=2. A response in cycle N goes to the first owner; mem_req=1 again in cycle N+1.
5. Data request accepted, then inst request accepted; two mem_data_ok pulses → data_data_ok first, inst_data_ok second; never both in the same cycle.
6. mem_data_ok with the FIFO empty → no *_data_ok, err_unexp=1 and held; reset asserted → err_unexp=0 and all handshake outputs 0.
